// File: rtl/serial_loader_pkg.sv
// Shared types and defaults for the serial word loader and its error counter.
package serial_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int ERRW_DEF  = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 4
) (
    input  logic         clk_sys,
    input  logic         rst_b,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk_sys or negedge rst_b) begin
        if (!rst_b) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_word_loader.sv
// Strobe-timed serial framer: start, WIDTH data bits LSB-first, optional even parity, stop.
// Good frames update D with a one-cycle load pulse for the downstream load register.
//
// state  | meaning
// IDLE   | waiting for a start bit (sdata=0 on a strobe)
// DATA   | shifting in WIDTH data bits, LSB first
// PARITY | sampling the even-parity bit
// STOP   | sampling the stop bit and reporting the frame outcome
module serial_word_loader
    import serial_loader_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter bit PARITY_EN = 1'b1,
    parameter int ERRW      = ERRW_DEF
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             sdata,
    input  logic             err_clr,
    output logic [WIDTH-1:0] D,
    output logic             load,
    output logic             busy,
    output logic             frame_err,
    output logic             parity_err,
    output logic [ERRW-1:0]  err_cnt
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic             p_ok;

    logic             start_sample;
    logic             data_sample;
    logic             parity_sample;
    logic             load_nxt;
    logic             frame_err_nxt;
    logic             parity_err_nxt;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bit_en) begin
            case (state)
                IDLE:    if (!sdata) state_nxt = DATA;
                DATA:    if (bit_cnt == LAST_BIT) state_nxt = PARITY_EN ? PARITY : STOP;
                PARITY:  state_nxt = STOP;
                STOP:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        start_sample   = bit_en && (state == IDLE) && !sdata;
        data_sample    = bit_en && (state == DATA);
        parity_sample  = bit_en && (state == PARITY);
        load_nxt       = 1'b0;
        frame_err_nxt  = 1'b0;
        parity_err_nxt = 1'b0;
        if (bit_en && (state == STOP)) begin
            // a bad stop bit masks any parity problem in the same frame
            if (!sdata) begin
                frame_err_nxt = 1'b1;
            end else if (PARITY_EN && !p_ok) begin
                parity_err_nxt = 1'b1;
            end else begin
                load_nxt = 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            bit_cnt <= '0;
            shreg   <= '0;
            p_ok    <= 1'b0;
        end else begin
            if (start_sample) begin
                bit_cnt <= '0;
            end else if (data_sample) begin
                shreg[bit_cnt] <= sdata;
                bit_cnt        <= bit_cnt + 1'b1;
            end
            if (parity_sample) begin
                p_ok <= ~(^shreg ^ sdata);
            end
        end
    end

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            D          <= '0;
            load       <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            load       <= load_nxt;
            frame_err  <= frame_err_nxt;
            parity_err <= parity_err_nxt;
            if (load_nxt) begin
                D <= shreg;
            end
        end
    end

    sat_counter #(
        .W (ERRW)
    ) u_err_cnt (
        .clk_sys (Clk),
        .rst_b   (reset),
        .inc     (frame_err | parity_err),
        .clr     (err_clr),
        .cnt     (err_cnt)
    );

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: stimulus pushes expected outcomes, a monitor pops them.
module tb_serial_word_loader;

    localparam int K_LOAD = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;

    logic       Clk;
    logic       reset;
    logic       bit_en;
    logic       sdata;
    logic       err_clr;
    logic [3:0] D;
    logic       load;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic [3:0] err_cnt;

    typedef struct {
        int         kind;
        logic [3:0] d;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    logic [3:0] last_good;
    int   err_model;

    serial_word_loader #(
        .WIDTH     (4),
        .PARITY_EN (1'b1),
        .ERRW      (4)
    ) dut (
        .Clk        (Clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .sdata      (sdata),
        .err_clr    (err_clr),
        .D          (D),
        .load       (load),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .err_cnt    (err_cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // monitor: every output event must match the oldest expected outcome
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge Clk);
            if (reset && (load || frame_err || parity_err)) begin
                chk("one_pulse", int'(load) + int'(frame_err) + int'(parity_err), 1);
                k = load ? K_LOAD : (frame_err ? K_FERR : K_PERR);
                if (q.size() == 0) begin
                    chk("spurious_event", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("event_kind", k, e.kind);
                    chk("D_value", int'(D), int'(e.d));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk); #1;
            bit_en = 1'b0;
            sdata  = 1'b1;
        end
    endtask

    task automatic strobe(input logic b, input int gapmax);
        int gap;
        gap = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        repeat (gap) begin
            @(posedge Clk); #1;
            bit_en = 1'b0;
            sdata  = 1'($urandom);
        end
        @(posedge Clk); #1;
        bit_en = 1'b1;
        sdata  = b;
    endtask

    // kind: K_LOAD good frame, K_FERR stop bit 0, K_PERR wrong parity bit
    task automatic send_frame(input logic [3:0] data, input int kind, input int gapmax,
                              input bit clr_at_stop);
        exp_t e;
        logic par;
        par = ^data;
        if (kind == K_PERR) par = ~par;
        if (kind == K_FERR && $urandom_range(1, 0) == 1) par = ~par;
        e.kind = kind;
        if (kind == K_LOAD) last_good = data;
        e.d = last_good;
        q.push_back(e);
        if (kind != K_LOAD) err_model = (err_model < 15) ? err_model + 1 : 15;
        if (clr_at_stop) err_model = 0;
        strobe(1'b0, gapmax);
        for (int i = 0; i < 4; i++) strobe(data[i], gapmax);
        strobe(par, gapmax);
        strobe((kind == K_FERR) ? 1'b0 : 1'b1, gapmax);
        if (clr_at_stop) begin
            err_clr = 1'b1;
            idle(2);
            err_clr = 1'b0;
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        last_good = 4'h0;
        err_model = 0;
        reset     = 1'b0;
        bit_en    = 1'b0;
        sdata     = 1'b1;
        err_clr   = 1'b0;

        // held in reset while inputs wiggle
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            bit_en = 1'($urandom);
            sdata  = 1'($urandom);
            @(negedge Clk);
            chk("rst_D", int'(D), 0);
            chk("rst_load", int'(load), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_err_cnt", int'(err_cnt), 0);
        end
        @(posedge Clk); #1;
        bit_en = 1'b0;
        sdata  = 1'b1;
        reset  = 1'b1;
        idle(2);

        // directed good frame 0xD, then the same frame with a bad parity bit
        send_frame(4'hD, K_LOAD, 0, 1'b0);
        idle(3);
        chk("busy_after_good", int'(busy), 0);
        chk("D_after_good", int'(D), 13);
        send_frame(4'hD, K_PERR, 0, 1'b0);
        idle(3);
        chk("err_cnt_parity", int'(err_cnt), err_model);
        chk("D_held_parity", int'(D), 13);

        // frame errors until saturation
        for (int i = 0; i < 20; i++) begin
            send_frame(4'($urandom), K_FERR, 2, 1'b0);
            idle(3);
            chk("err_cnt_sat", int'(err_cnt), err_model);
        end
        chk("err_cnt_top", int'(err_cnt), 15);

        // clear coinciding with an error
        send_frame(4'h5, K_FERR, 0, 1'b1);
        idle(3);
        chk("err_clr_wins", int'(err_cnt), 0);

        // back-to-back frames with no idle strobe
        send_frame(4'h3, K_LOAD, 0, 1'b0);
        send_frame(4'hA, K_LOAD, 0, 1'b0);
        idle(3);
        chk("D_back_to_back", int'(D), 10);

        // reset after the 2nd data bit
        strobe(1'b0, 3);
        strobe(1'b1, 3);
        strobe(1'b0, 3);
        @(posedge Clk); #1;
        bit_en = 1'b0;
        @(negedge Clk);
        chk("busy_mid_frame", int'(busy), 1);
        reset = 1'b0;
        #1;
        chk("midrst_D", int'(D), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        last_good = 4'h0;
        err_model = 0;
        idle(2);
        reset = 1'b1;
        idle(1);
        send_frame(4'h6, K_LOAD, 4, 1'b0);
        idle(3);
        chk("D_after_midrst", int'(D), 6);

        // randomized frames with strobe gaps 0-7
        for (int i = 0; i < 30; i++) begin
            int r;
            r = int'($urandom_range(9, 0));
            send_frame(4'($urandom), (r < 6) ? K_LOAD : ((r < 8) ? K_FERR : K_PERR), 7, 1'b0);
            if ($urandom_range(1, 0) == 1) idle(int'($urandom_range(3, 0)));
        end
        idle(4);
        chk("err_cnt_random", int'(err_cnt), err_model);
        chk("D_final", int'(D), int'(last_good));
        chk("busy_final", int'(busy), 0);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
